axi_rr_arbiter: RTL and testbench

Parametrised N-to-1 AXI4 arbiter that merges several core-side AXI4 masters onto the single `io_master` port of the `ysyx_24080008` top. Typical masters are instruction fetch, load/store and a future DMA. Read and write channels are arbitrated independently, each by its own round-robin state machine. Each direction allows one outstanding transaction, bursts included.

---
 rtl/axi_rr_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: N-to-1 AXI4 arbiter with independent read and write round-robin FSMs.
// Define AXI_ARB_FIXED_PRIO_EN to switch both arbiters to fixed lowest-index priority.
module axi_rr_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_M-1:0]            s_arvalid,
  output logic [NUM_M-1:0]            s_arready,
  input  logic [NUM_M*ADDR_W-1:0]     s_araddr,
  input  logic [NUM_M*ID_W-1:0]       s_arid,
  input  logic [NUM_M*8-1:0]          s_arlen,
  input  logic [NUM_M*3-1:0]          s_arsize,
  input  logic [NUM_M*2-1:0]          s_arburst,
  output logic [NUM_M-1:0]            s_rvalid,
  input  logic [NUM_M-1:0]            s_rready,
  output logic [DATA_W-1:0]           s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rlast,
  output logic [ID_W-1:0]             s_rid,
  input  logic [NUM_M-1:0]            s_awvalid,
  output logic [NUM_M-1:0]            s_awready,
  input  logic [NUM_M*ADDR_W-1:0]     s_awaddr,
  input  logic [NUM_M*ID_W-1:0]       s_awid,
  input  logic [NUM_M*8-1:0]          s_awlen,
  input  logic [NUM_M*3-1:0]          s_awsize,
  input  logic [NUM_M*2-1:0]          s_awburst,
  input  logic [NUM_M-1:0]            s_wvalid,
  output logic [NUM_M-1:0]            s_wready,
  input  logic [NUM_M*DATA_W-1:0]     s_wdata,
  input  logic [NUM_M*(DATA_W/8)-1:0] s_wstrb,
  input  logic [NUM_M-1:0]            s_wlast,
  output logic [NUM_M-1:0]            s_bvalid,
  input  logic [NUM_M-1:0]            s_bready,
  output logic [1:0]                  s_bresp,
  output logic [ID_W-1:0]             s_bid,
  input  logic                        m_awready,
  output logic                        m_awvalid,
  output logic [ADDR_W-1:0]           m_awaddr,
  output logic [ID_W-1:0]             m_awid,
  output logic [7:0]                  m_awlen,
  output logic [2:0]                  m_awsize,
  output logic [1:0]                  m_awburst,
  input  logic                        m_wready,
  output logic                        m_wvalid,
  output logic [DATA_W-1:0]           m_wdata,
  output logic [DATA_W/8-1:0]         m_wstrb,
  output logic                        m_wlast,
  output logic                        m_bready,
  input  logic                        m_bvalid,
  input  logic [1:0]                  m_bresp,
  input  logic [ID_W-1:0]             m_bid,
  input  logic                        m_arready,
  output logic                        m_arvalid,
  output logic [ADDR_W-1:0]           m_araddr,
  output logic [ID_W-1:0]             m_arid,
  output logic [7:0]                  m_arlen,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  output logic                        m_rready,
  input  logic                        m_rvalid,
  input  logic [1:0]                  m_rresp,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic                        m_rlast,
  input  logic [ID_W-1:0]             m_rid
);
  localparam int IW = $clog2(NUM_M);
  localparam int SW = DATA_W / 8;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
  r_state_t r_rstate;
  w_state_t r_wstate;
  logic [IW-1:0] r_rg, r_wg, w_rptr, w_wptr;
  logic r_aw_done, r_w_done;
  logic w_ra, w_rd, w_wx, w_wr, w_aw, w_w, w_r_end, w_b_hs, w_aw_hs, w_wl_hs;
  // First requester at or above ptr, wrapping; scanning downward lets the nearest one win.
  function automatic logic [IW-1:0] pick(input logic [NUM_M-1:0] req, input logic [IW-1:0] ptr);
    int k;
    logic [IW-1:0] kk;
    pick = ptr;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NUM_M;
      kk = IW'(k);
      if (req[kk]) pick = kk;
    end
  endfunction
  assign w_ra = r_rstate == R_ADDR;
  assign w_rd = r_rstate == R_DATA;
  assign w_wx = r_wstate == W_XFER;
  assign w_wr = r_wstate == W_RESP;
  assign w_aw = w_wx & ~r_aw_done;
  assign w_w  = w_wx & ~r_w_done;
  assign w_r_end = w_rd & m_rvalid & s_rready[r_rg] & m_rlast;
  assign w_b_hs  = w_wr & m_bvalid & s_bready[r_wg];
  assign w_aw_hs = w_aw & m_awready;
  assign w_wl_hs = w_w & s_wvalid[r_wg] & m_wready & s_wlast[r_wg];
`ifdef AXI_ARB_FIXED_PRIO_EN
  assign w_rptr = '0;
  assign w_wptr = '0;
`else
  logic [IW-1:0] r_rptr, r_wptr;
  assign w_rptr = r_rptr;
  assign w_wptr = r_wptr;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      if (w_r_end) r_rptr <= r_rg == IW'(NUM_M - 1) ? '0 : r_rg + 1'b1;
      if (w_b_hs) r_wptr <= r_wg == IW'(NUM_M - 1) ? '0 : r_wg + 1'b1;
    end
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_rstate <= R_IDLE;
      r_rg <= '0;
    end else
      case (r_rstate)
        R_IDLE: if (|s_arvalid) begin
          r_rg <= pick(s_arvalid, w_rptr);
          r_rstate <= R_ADDR;
        end
        R_ADDR: if (m_arready) r_rstate <= R_DATA;
        R_DATA: if (w_r_end) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_wstate <= W_IDLE;
      r_wg <= '0;
      r_aw_done <= 1'b0;
      r_w_done <= 1'b0;
    end else
      case (r_wstate)
        W_IDLE: if (|s_awvalid) begin
          r_wg <= pick(s_awvalid, w_wptr);
          r_wstate <= W_XFER;
        end
        W_XFER: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_wl_hs) r_w_done <= 1'b1;
          if (r_aw_done && r_w_done) r_wstate <= W_RESP;
        end
        W_RESP: if (w_b_hs) begin
          r_wstate <= W_IDLE;
          r_aw_done <= 1'b0;
          r_w_done <= 1'b0;
        end
        default: r_wstate <= W_IDLE;
      endcase
  always_comb begin
    s_arready = '0;
    s_rvalid = '0;
    s_awready = '0;
    s_wready = '0;
    s_bvalid = '0;
    s_arready[r_rg] = w_ra & m_arready;
    s_rvalid[r_rg] = w_rd & m_rvalid;
    s_awready[r_wg] = w_aw & m_awready;
    s_wready[r_wg] = w_w & m_wready;
    s_bvalid[r_wg] = w_wr & m_bvalid;
  end
  assign m_arvalid = w_ra;
  assign m_araddr  = w_ra ? s_araddr[r_rg*ADDR_W +: ADDR_W] : '0;
  assign m_arid    = w_ra ? s_arid[r_rg*ID_W +: ID_W] : '0;
  assign m_arlen   = w_ra ? s_arlen[r_rg*8 +: 8] : '0;
  assign m_arsize  = w_ra ? s_arsize[r_rg*3 +: 3] : '0;
  assign m_arburst = w_ra ? s_arburst[r_rg*2 +: 2] : '0;
  assign m_rready  = w_rd & s_rready[r_rg];
  assign s_rdata   = w_rd ? m_rdata : '0;
  assign s_rresp   = w_rd ? m_rresp : '0;
  assign s_rlast   = w_rd & m_rlast;
  assign s_rid     = w_rd ? m_rid : '0;
  assign m_awvalid = w_aw;
  assign m_awaddr  = w_aw ? s_awaddr[r_wg*ADDR_W +: ADDR_W] : '0;
  assign m_awid    = w_aw ? s_awid[r_wg*ID_W +: ID_W] : '0;
  assign m_awlen   = w_aw ? s_awlen[r_wg*8 +: 8] : '0;
  assign m_awsize  = w_aw ? s_awsize[r_wg*3 +: 3] : '0;
  assign m_awburst = w_aw ? s_awburst[r_wg*2 +: 2] : '0;
  assign m_wvalid  = w_w & s_wvalid[r_wg];
  assign m_wdata   = w_w ? s_wdata[r_wg*DATA_W +: DATA_W] : '0;
  assign m_wstrb   = w_w ? s_wstrb[r_wg*SW +: SW] : '0;
  assign m_wlast   = w_w & s_wlast[r_wg];
  assign m_bready  = w_wr & s_bready[r_wg];
  assign s_bresp   = w_wr ? m_bresp : '0;
  assign s_bid     = w_wr ? m_bid : '0;
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter: directed vectors for axi_rr_arbiter with hand-computed expectations.
module tb_axi_rr_arbiter;
  localparam int N = 2, AW = 32, DW = 32, IDW = 4;
`ifdef AXI_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0;
  logic [N-1:0] s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic [N-1:0] s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [N*AW-1:0] s_araddr, s_awaddr;
  logic [N*IDW-1:0] s_arid, s_awid;
  logic [N*8-1:0] s_arlen, s_awlen;
  logic [N*3-1:0] s_arsize, s_awsize;
  logic [N*2-1:0] s_arburst, s_awburst;
  logic [N*DW-1:0] s_wdata;
  logic [N*(DW/8)-1:0] s_wstrb;
  logic [DW-1:0] s_rdata, m_wdata, m_rdata;
  logic [1:0] s_rresp, s_bresp, m_bresp, m_rresp, m_awburst, m_arburst;
  logic s_rlast, m_awready, m_awvalid, m_wready, m_wvalid, m_wlast, m_bready, m_bvalid;
  logic m_arready, m_arvalid, m_rready, m_rvalid, m_rlast;
  logic [IDW-1:0] s_rid, s_bid, m_awid, m_bid, m_arid, m_rid;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_arsize;
  logic [DW/8-1:0] m_wstrb;
  int n_cmp = 0, n_err = 0;
  always #5 clock = ~clock;
  axi_rr_arbiter #(.NUM_M(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IDW)) dut (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .m_awready(m_awready), .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wready(m_wready), .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bready(m_bready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid),
    .m_arready(m_arready), .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rready(m_rready), .m_rvalid(m_rvalid), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rid(m_rid)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic clr();
    {s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready} = '0;
    {s_araddr, s_awaddr, s_arid, s_awid, s_arlen, s_awlen} = '0;
    {s_arsize, s_awsize, s_arburst, s_awburst, s_wdata, s_wstrb} = '0;
    {m_awready, m_wready, m_bvalid, m_bresp, m_bid} = '0;
    {m_arready, m_rvalid, m_rresp, m_rdata, m_rlast, m_rid} = '0;
  endtask
  task automatic do_reset();
    clr();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end
  initial begin
    int g;
    clr();
    #2;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_wready", s_wready, 0);
    chk("rst_araddr", m_araddr, 0);
    step();
    reset = 1'b1;
    // single 4-beat read from master 0
    s_arvalid = 2'b01; s_araddr[31:0] = 32'h8000_0000; s_arlen[7:0] = 8'd3; s_arid[3:0] = 4'h5;
    #1 chk("t1_pre_arvalid", m_arvalid, 0);
    step();
    chk("t1_arvalid", m_arvalid, 1);
    chk("t1_araddr", m_araddr, 32'h8000_0000);
    chk("t1_arlen", m_arlen, 3);
    chk("t1_arid", m_arid, 5);
    m_arready = 1'b1;
    #1 chk("t1_arready", s_arready, 2'b01);
    step();
    s_arvalid = '0; m_arready = 1'b0; s_rready = 2'b11;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rdata = 32'hd0 + b; m_rlast = (b == 3); m_rid = 4'h5;
      #1;
      chk("t1_rvalid", s_rvalid, 2'b01);
      chk("t1_rdata", s_rdata, 32'hd0 + b);
      chk("t1_rlast", s_rlast, b == 3);
      chk("t1_rid", s_rid, 5);
      step();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("t1_end_rready", m_rready, 0);
    chk("t1_end_rvalid", s_rvalid, 0);
    chk("t1_end_arvalid", m_arvalid, 0);
    // reset mid-burst; the read pointer was left at 1 by test 1
    s_arvalid = 2'b01; s_arlen[7:0] = 8'd3;
    step();
    m_arready = 1'b1;
    step();
    s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1;
    step();
    m_rdata = 32'h2;
    #1 chk("t5_beat2_rvalid", s_rvalid, 2'b01);
    reset = 1'b0;
    #1;
    chk("t5_rst_rvalid", s_rvalid, 0);
    chk("t5_rst_rready", m_rready, 0);
    chk("t5_rst_arvalid", m_arvalid, 0);
    chk("t5_rst_rdata", s_rdata, 0);
    m_rvalid = 1'b0;
    step();
    reset = 1'b1;
    s_arvalid = 2'b11; s_araddr[63:32] = 32'h200; s_arlen = '0;
    step();
    m_arready = 1'b1;
    #1;
    chk("t5_grant0", s_arready, 2'b01);
    chk("t5_araddr", m_araddr, 32'h8000_0000);
    // round-robin fairness, both masters hold arvalid
    do_reset();
    s_arvalid = 2'b11; s_araddr = {32'h200, 32'h100}; s_rready = 2'b11;
    step();
    for (int i = 0; i < 4; i++) begin
      g = FIXED ? 0 : i % 2;
      m_arready = 1'b1;
      #1;
      chk("t2_arready", s_arready, 64'(1 << g));
      chk("t2_araddr", m_araddr, g ? 32'h200 : 32'h100);
      step();
      m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
      #1 chk("t2_rvalid", s_rvalid, 64'(1 << g));
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0;
      #1 chk("t2_gap", m_arvalid, 0);
      step();
    end
    // master 1 presents its wlast beat well before AW is accepted
    do_reset();
    s_awvalid = 2'b10; s_awaddr[63:32] = 32'h2000; s_awid[7:4] = 4'h9;
    s_wvalid = 2'b10; s_wdata[63:32] = 32'hcafe; s_wstrb[7:4] = 4'hf; s_wlast = 2'b10;
    m_wready = 1'b1; s_bready = 2'b10;
    step();
    chk("t3_awvalid", m_awvalid, 1);
    chk("t3_awid", m_awid, 9);
    chk("t3_wvalid", m_wvalid, 1);
    chk("t3_wdata", m_wdata, 32'hcafe);
    chk("t3_wready", s_wready, 2'b10);
    chk("t3_awready", s_awready, 0);
    step();
    s_wvalid = '0; s_wlast = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_wait_wvalid", m_wvalid, 0);
      chk("t3_wait_bready", m_bready, 0);
      chk("t3_wait_awvalid", m_awvalid, 1);
      step();
    end
    m_awready = 1'b1;
    #1 chk("t3_awready_hs", s_awready, 2'b10);
    step();
    s_awvalid = '0; m_awready = 1'b0;
    #1;
    chk("t3_post_aw_awvalid", m_awvalid, 0);
    chk("t3_post_aw_bready", m_bready, 0);
    step();
    m_bvalid = 1'b1; m_bid = 4'h9; m_bresp = 2'b00;
    #1;
    chk("t3_bvalid", s_bvalid, 2'b10);
    chk("t3_bid", s_bid, 9);
    chk("t3_bresp", s_bresp, 0);
    chk("t3_bready", m_bready, 1);
    step();
    m_bvalid = 1'b0;
    #1 chk("t3_end_bvalid", s_bvalid, 0);
    // concurrent read by master 0 and write by master 1
    do_reset();
    s_arvalid = 2'b01; s_araddr[31:0] = 32'h3000; s_rready = 2'b01;
    s_awvalid = 2'b10; s_awaddr[63:32] = 32'h1000_0000;
    s_wvalid = 2'b10; s_wstrb[7:4] = 4'h1; s_wlast = 2'b10; s_wdata[63:32] = 32'h55; s_bready = 2'b10;
    step();
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    #1;
    chk("t4_arvalid", m_arvalid, 1);
    chk("t4_araddr", m_araddr, 32'h3000);
    chk("t4_awvalid", m_awvalid, 1);
    chk("t4_awaddr", m_awaddr, 32'h1000_0000);
    chk("t4_wstrb", m_wstrb, 4'h1);
    chk("t4_arready", s_arready, 2'b01);
    chk("t4_awready", s_awready, 2'b10);
    chk("t4_wready", s_wready, 2'b10);
    step();
    s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    chk("t4_rvalid", s_rvalid, 2'b01);
    chk("t4_rready", m_rready, 1);
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b1;
    #1;
    chk("t4_bvalid", s_bvalid, 2'b10);
    chk("t4_bready", m_bready, 1);
    step();
    m_bvalid = 1'b0;
    #1;
    chk("t4_end_bvalid", s_bvalid, 0);
    chk("t4_end_awvalid", m_awvalid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
